// File: rtl/seq_detector_multi_if.sv
// Stream, config and status signals of seq_detector_multi.
// The master drives the stream and config writes; the slave (the detector)
// returns hit pulses and hit counters.
interface seq_detector_multi_if #(
  parameter int SEQ_WIDTH = 8,
  parameter int NUM_PAT   = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int IDXW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  logic                         clr;
  logic                         in_valid;
  logic                         in_bit;
  logic                         cfg_we;
  logic [IDXW-1:0]              cfg_idx;
  logic [SEQ_WIDTH-1:0]         cfg_pat;
  logic [SEQ_WIDTH-1:0]         cfg_mask;
  logic                         cfg_ovl;
  logic [NUM_PAT-1:0]           hit;
  logic                         hit_any;
  logic [NUM_PAT*CNT_WIDTH-1:0] hit_cnt;

  modport master (
    output clr, in_valid, in_bit, cfg_we, cfg_idx, cfg_pat, cfg_mask, cfg_ovl,
    input  hit, hit_any, hit_cnt
  );

  modport slave (
    input  clr, in_valid, in_bit, cfg_we, cfg_idx, cfg_pat, cfg_mask, cfg_ovl,
    output hit, hit_any, hit_cnt
  );
endinterface

// File: rtl/seq_detector_multi.sv
// Runtime-programmable multi-pattern serial sequence detector.
// One valid-qualified bitstream is matched in parallel against NUM_PAT
// masked patterns, each in overlapping or non-overlapping mode.
// Optional feature: define SEQ_DET_HIT_CNT_EN to build saturating per-pattern
// hit counters; without it hit_cnt is tied to zero.
module seq_detector_multi #(
  parameter int SEQ_WIDTH = 8,
  parameter int NUM_PAT   = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  seq_detector_multi_if.slave bus
);
  localparam int IDXW  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam int FILLW = $clog2(SEQ_WIDTH + 1);
  localparam logic [FILLW-1:0] FILL_MAX = FILLW'(SEQ_WIDTH);

  logic [SEQ_WIDTH-1:0] hist_q;
  logic [SEQ_WIDTH-1:0] hist_next;
  logic [FILLW-1:0]     fill_q;
  logic [FILLW-1:0]     fill_next;
  logic [FILLW-1:0]     since_q    [NUM_PAT];
  logic [FILLW-1:0]     since_next [NUM_PAT];
  logic [SEQ_WIDTH-1:0] pat_q      [NUM_PAT];
  logic [SEQ_WIDTH-1:0] mask_q     [NUM_PAT];
  logic [NUM_PAT-1:0]   ovl_q;
  logic [NUM_PAT-1:0]   cfg_sel;
  logic [NUM_PAT-1:0]   match;
  logic [NUM_PAT-1:0]   hit_q;
  logic                 hit_any_q;

  // Next-state history and saturating fill count for the bit offered this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    hist_next = hist_q;
    fill_next = fill_q;
    if (bus.in_valid) begin
      hist_next = {hist_q[SEQ_WIDTH-2:0], bus.in_bit};
      if (fill_q != FILL_MAX) fill_next = fill_q + FILLW'(1);
    end
  end

  // Per-pattern match decision, made on the history as it will be after this bit.
  always_comb begin
    for (int i = 0; i < NUM_PAT; i++) begin
      // Out-of-range indices never equal a slot number, so they write nothing.
      cfg_sel[i]    = bus.cfg_we && (bus.cfg_idx == IDXW'(i));
      since_next[i] = since_q[i];
      if (bus.in_valid && since_q[i] != FILL_MAX) since_next[i] = since_q[i] + FILLW'(1);
      // A slot being rewritten never reports a hit on the old config's last bit.
      match[i] = bus.in_valid
              && (mask_q[i] != '0)
              && (((hist_next ^ pat_q[i]) & mask_q[i]) == '0)
              && (fill_next >= FILL_MAX)
              && (ovl_q[i] || since_next[i] >= FILL_MAX)
              && !cfg_sel[i];
    end
  end

  // Stream state, config slots and registered hit pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      hit_q     <= '0;
      hit_any_q <= 1'b0;
      ovl_q     <= '0;
      // NOTE: the config slots are reset on purpose; a zero mask is the "disabled" state.
      for (int i = 0; i < NUM_PAT; i++) begin
        since_q[i] <= '0;
        pat_q[i]   <= '0;
        mask_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (cfg_sel[i]) begin
          pat_q[i]  <= bus.cfg_pat;
          mask_q[i] <= bus.cfg_mask;
          ovl_q[i]  <= bus.cfg_ovl;
        end
      end
      if (bus.clr) begin
        // The bit offered alongside clr is dropped; config is kept.
        hist_q    <= '0;
        fill_q    <= '0;
        hit_q     <= '0;
        hit_any_q <= 1'b0;
        for (int i = 0; i < NUM_PAT; i++) since_q[i] <= '0;
      end else begin
        hist_q    <= hist_next;
        fill_q    <= fill_next;
        hit_q     <= match;
        hit_any_q <= |match;
        // A hit or a rewrite restarts the non-overlap spacing for that slot.
        for (int i = 0; i < NUM_PAT; i++)
          since_q[i] <= (match[i] || cfg_sel[i]) ? '0 : since_next[i];
      end
    end
  end

  assign bus.hit     = hit_q;
  assign bus.hit_any = hit_any_q;

`ifdef SEQ_DET_HIT_CNT_EN
  logic [CNT_WIDTH-1:0]         cnt_q [NUM_PAT];
  logic [NUM_PAT*CNT_WIDTH-1:0] cnt_flat;

  // Saturating hit counters, bumped on the same edge that raises the hit pulse.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      for (int i = 0; i < NUM_PAT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PAT; i++)
        if (match[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
    end
  end

  // Flatten the counters onto the status bus, pattern i in slice i.
  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_PAT; i++) cnt_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

  assign bus.hit_cnt = cnt_flat;
`else
  assign bus.hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_multi.sv
// Self-checking bench for seq_detector_multi (SEQ_WIDTH=4, NUM_PAT=2,
// CNT_WIDTH=2). Counter expectations follow SEQ_DET_HIT_CNT_EN.
`timescale 1ns/1ps
module tb_seq_detector_multi;
  localparam int SW      = 4;
  localparam int NP      = 2;
  localparam int CW      = 2;
  localparam int IDXW    = 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_multi_if #(.SEQ_WIDTH(SW), .NUM_PAT(NP), .CNT_WIDTH(CW)) bus ();

  seq_detector_multi #(.SEQ_WIDTH(SW), .NUM_PAT(NP), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit            r;
    bit            c;
    bit            v;
    bit            b;
    bit            we;
    bit [IDXW-1:0] idx;
    bit [SW-1:0]   pat;
    bit [SW-1:0]   mask;
    bit            ovl;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit [NP-1:0] eh;
    int          ec0;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of consumed bits, bit position of the last
  // hit/rewrite per pattern, and the programmed slots.
  bit          stream_q[$];
  int          n_bits;
  int          anchor [NP];
  bit [SW-1:0] m_pat  [NP];
  bit [SW-1:0] m_mask [NP];
  bit          m_ovl  [NP];
  int          m_cnt  [NP];
  bit [NP-1:0] m_hit;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef SEQ_DET_HIT_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic bit [SW-1:0] window();
    int w = 0;
    foreach (stream_q[k]) w = w * 2 + int'(stream_q[k]);
    return SW'(w);
  endfunction

  function automatic void model_step(input stim_t s);
    bit [NP-1:0] h = '0;
    if (s.r) begin
      stream_q.delete();
      n_bits = 0;
      for (int i = 0; i < NP; i++) begin
        anchor[i] = 0; m_pat[i] = '0; m_mask[i] = '0; m_ovl[i] = 1'b0; m_cnt[i] = 0;
      end
      m_hit = '0;
      return;
    end
    if (s.c) begin
      stream_q.delete();
      n_bits = 0;
      for (int i = 0; i < NP; i++) begin
        anchor[i] = 0; m_cnt[i] = 0;
      end
    end else if (s.v) begin
      stream_q.push_back(s.b);
      if (stream_q.size() > SW) void'(stream_q.pop_front());
      n_bits++;
      for (int i = 0; i < NP; i++) begin
        bit rewritten;
        rewritten = s.we && (int'(s.idx) == i);
        if (!rewritten && m_mask[i] != '0 && n_bits >= SW &&
            ((window() ^ m_pat[i]) & m_mask[i]) == '0 &&
            (m_ovl[i] || (n_bits - anchor[i]) >= SW)) begin
          h[i]      = 1'b1;
          anchor[i] = n_bits;
          if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
        end
      end
    end
    m_hit = h;
    if (s.we && int'(s.idx) < NP) begin
      m_pat[s.idx]  = s.pat;
      m_mask[s.idx] = s.mask;
      m_ovl[s.idx]  = s.ovl;
      anchor[s.idx] = n_bits;
    end
  endfunction

  function automatic logic [NP*CW-1:0] exp_cnt_flat();
    logic [NP*CW-1:0] f = '0;
    for (int i = 0; i < NP; i++) f[i*CW +: CW] = CW'(cnt_exp(m_cnt[i]));
    return f;
  endfunction

  // One clock: apply inputs, step the model, compare just after the edge.
  task automatic drive(input stim_t s);
    rst          = s.r;
    bus.clr      = s.c;
    bus.in_valid = s.v;
    bus.in_bit   = s.b;
    bus.cfg_we   = s.we;
    bus.cfg_idx  = s.idx;
    bus.cfg_pat  = s.pat;
    bus.cfg_mask = s.mask;
    bus.cfg_ovl  = s.ovl;
    model_step(s);
    @(posedge clk);
    #1;
    check("model_hit", 32'(bus.hit), 32'(m_hit));
    check("model_hit_any", 32'(bus.hit_any), 32'(|m_hit));
    check("model_hit_cnt", 32'(bus.hit_cnt), 32'(exp_cnt_flat()));
  endtask

  task automatic expect_out(input string tag, input bit [NP-1:0] eh, input int ec0);
    check({tag, "_hit"}, 32'(bus.hit), 32'(eh));
    check({tag, "_hit_any"}, 32'(bus.hit_any), 32'(|eh));
    check({tag, "_cnt0"}, 32'(bus.hit_cnt[CW-1:0]), 32'(cnt_exp(ec0)));
  endtask

  function automatic stim_t st_idle();
    stim_t s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t st_bit(input bit b);
    stim_t s = '{default: 0};
    s.v = 1'b1;
    s.b = b;
    return s;
  endfunction

  function automatic stim_t st_cfg(input int idx, input bit [SW-1:0] pat,
                                   input bit [SW-1:0] mask, input bit ovl);
    stim_t s = '{default: 0};
    s.we   = 1'b1;
    s.idx  = IDXW'(idx);
    s.pat  = pat;
    s.mask = mask;
    s.ovl  = ovl;
    return s;
  endfunction

  task automatic add(input stim_t s, input bit [NP-1:0] eh, input int ec0);
    vec_t v;
    v.s   = s;
    v.eh  = eh;
    v.ec0 = ec0;
    tbl.push_back(v);
  endtask

  initial begin
    stim_t s;
    bit    a_bits [13] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int    a_cnt  [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int    b_cnt  [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2};

    // Reset state
    s = st_idle(); s.r = 1'b1;
    drive(s);
    drive(s);
    expect_out("reset", 2'b00, 0);
    check("reset_hit_cnt_all", 32'(bus.hit_cnt), 32'd0);

    // Overlapping: 1001 on 1001001001001 hits at bits 4,7,10,13, counter saturates at 3
    add(st_cfg(0, 4'b1001, 4'b1111, 1'b1), 2'b00, 0);
    for (int k = 0; k < 13; k++)
      add(st_bit(a_bits[k]), (k > 0 && k % 3 == 0) ? 2'b01 : 2'b00, a_cnt[k]);
    // Non-overlapping after clr: hits at bits 4 and 10 only
    s = st_cfg(0, 4'b1001, 4'b1111, 1'b0); s.c = 1'b1;
    add(s, 2'b00, 0);
    for (int k = 0; k < 10; k++)
      add(st_bit(a_bits[k]), (k == 3 || k == 9) ? 2'b01 : 2'b00, b_cnt[k]);
    // Don't-care mask: pat1 1001/1001 hits on 1111, pat0 1001/1111 does not
    s = st_cfg(1, 4'b1001, 4'b1001, 1'b1); s.c = 1'b1;
    add(s, 2'b00, 0);
    for (int k = 0; k < 5; k++)
      add(st_bit(1'b1), (k >= 3) ? 2'b10 : 2'b00, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].s);
      expect_out($sformatf("tbl%0d", k), tbl[k].eh, tbl[k].ec0);
    end

    // Fill guard and valid gaps
    s = st_idle(); s.r = 1'b1;
    drive(s);
    drive(st_cfg(0, 4'b0001, 4'b1111, 1'b1));
    drive(st_bit(1'b0)); drive(st_idle());
    drive(st_bit(1'b0)); drive(st_idle());
    drive(st_bit(1'b1)); expect_out("fill_short", 2'b00, 0);
    drive(st_idle());    expect_out("fill_gap", 2'b00, 0);
    drive(st_bit(1'b0)); drive(st_bit(1'b0)); drive(st_bit(1'b0));
    expect_out("fill_pre", 2'b00, 0);
    drive(st_bit(1'b1)); expect_out("fill_hit", 2'b01, 1);
    drive(st_idle());    expect_out("fill_pulse_end", 2'b00, 1);

    // Config write colliding with the completing bit
    drive(st_cfg(1, 4'b0001, 4'b0001, 1'b1));
    drive(st_bit(1'b0)); drive(st_bit(1'b0)); drive(st_bit(1'b0));
    expect_out("coll_pre", 2'b00, 1);
    s = st_cfg(0, 4'b0001, 4'b1111, 1'b1); s.v = 1'b1; s.b = 1'b1;
    drive(s);            expect_out("coll", 2'b10, 1);

    // clr mid-pattern: bit offered with clr is dropped, config retained
    drive(st_bit(1'b0)); drive(st_bit(1'b0));
    s = st_bit(1'b1); s.c = 1'b1;
    drive(s);            expect_out("clr", 2'b00, 0);
    drive(st_bit(1'b0)); drive(st_bit(1'b0));
    drive(st_bit(1'b1)); expect_out("clr_fill", 2'b00, 0);
    drive(st_bit(1'b1)); expect_out("clr_pat1", 2'b10, 0);
    drive(st_bit(1'b0)); drive(st_bit(1'b0)); drive(st_bit(1'b0));
    drive(st_bit(1'b1)); expect_out("clr_both", 2'b11, 1);

    // Reset during back-to-back hits
    s = st_cfg(0, 4'b1111, 4'b1111, 1'b1); s.c = 1'b1;
    drive(s);
    for (int k = 0; k < 3; k++) drive(st_bit(1'b1));
    expect_out("b2b_pre", 2'b00, 0);
    drive(st_bit(1'b1)); expect_out("b2b_1", 2'b11, 1);
    drive(st_bit(1'b1)); expect_out("b2b_2", 2'b11, 2);
    s = st_bit(1'b1); s.r = 1'b1;
    drive(s);            expect_out("rst_mid", 2'b00, 0);
    check("rst_mid_cnt_all", 32'(bus.hit_cnt), 32'd0);
    for (int k = 0; k < 6; k++) drive(st_bit(1'b1));
    expect_out("rst_disabled", 2'b00, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      s      = st_idle();
      s.r    = ($urandom_range(0, 499) == 0);
      s.c    = ($urandom_range(0, 99) == 0);
      s.v    = ($urandom_range(0, 3) != 0);
      s.b    = 1'($urandom_range(0, 1));
      s.we   = ($urandom_range(0, 39) == 0);
      s.idx  = IDXW'($urandom_range(0, NP - 1));
      s.pat  = SW'($urandom);
      s.mask = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
      s.ovl  = 1'($urandom_range(0, 1));
      drive(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detector_multi.md
# seq_detector_multi

Runtime-programmable multi-pattern serial sequence detector. It is the parametrised successor to the single fixed-pattern detector. A single input bitstream, qualified by a valid strobe, is matched in parallel against NUM_PAT patterns. Each pattern has its own don't-care mask and its own overlapping or non-overlapping mode, all programmed through a config write port. The block sits on the serial-stream path and produces registered per-pattern hit pulses and, optionally, saturating hit counters for status readout.

## Interface
- SEQ_WIDTH, 8: pattern length in bits; must be at least 2.
- NUM_PAT, 4: number of independent patterns; must be at least 1.
- CNT_WIDTH, 16: width of each hit counter.
- IDXW (localparam): max(1, $clog2(NUM_PAT)).
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous stream clear; preserves config.
- in_valid  in  1  in_bit is consumed this cycle.
- in_bit  in  1  serial input bit.
- cfg_we  in  1  config write strobe.
- cfg_idx  in  IDXW  pattern slot to write.
- cfg_pat  in  SEQ_WIDTH  pattern value; MSB is the oldest bit.
- cfg_mask  in  SEQ_WIDTH  care mask; 1 means compare this bit.
- cfg_ovl  in  1  1 selects overlapping mode, 0 selects non-overlapping.
- hit  out  NUM_PAT  per-pattern one-cycle match pulse.
- hit_any  out  1  OR of hit.
- hit_cnt  out  NUM_PAT*CNT_WIDTH  per-pattern counters, pattern i in slice [i*CNT_WIDTH +: CNT_WIDTH].

## Operation
- History register hist[SEQ_WIDTH-1:0]:
  - On in_valid, hist shifts to {hist[SEQ_WIDTH-2:0], in_bit}, so the newest bit is at the LSB.
  - Without in_valid, hist holds.
- Fill counter fill:
  - Saturating count of valid bits since rst or clr, capped at SEQ_WIDTH.
  - No pattern can hit until fill reaches SEQ_WIDTH. Zero-initialised history never produces a false match.
- Per-pattern "since" counter since[i]:
  - Saturating count of valid bits since pattern i last hit, capped at SEQ_WIDTH.
  - Cleared to 0 on a hit of pattern i, on rst, on clr, and on a cfg write to slot i.
- Match condition for pattern i, evaluated on the next-state history when in_valid is high:
  - Masked compare: ((hist_next ^ pat[i]) & mask[i]) == 0.
  - mask[i] is nonzero.
  - fill_next is at least SEQ_WIDTH.
  - If ovl[i] is 0, since_next[i] must also be at least SEQ_WIDTH. The bits of a hit are never reused by that pattern.
- Config writes:
  - cfg_we with cfg_idx < NUM_PAT loads pat, mask and ovl for that slot.
  - cfg_idx >= NUM_PAT is ignored.
  - A write to slot i in the same cycle as in_valid suppresses hit[i] for that cycle. since[i] is set to 0, so the current bit is not counted.
  - Other slots are unaffected. hist and fill still update.
- An all-zero mask disables the pattern.
- Reset values:
  - hist = 0, fill = 0, since = 0.
  - All pat = 0, all mask = 0 (all patterns disabled), all ovl = 0.
  - hit = 0, hit_any = 0, hit_cnt = 0.
- clr:
  - Same effect as rst on hist, fill, since, hit and hit_cnt. pat, mask and ovl are kept.
  - rst has priority over clr, and clr has priority over in_valid. A bit presented with clr is dropped.

## Timing
- Latency is 1 cycle. hit[i] is registered and goes high in the cycle after the edge that consumed the completing bit.
- hit[i] is high for exactly one cycle per match.
- Back-to-back hits are possible in overlapping mode with consecutive valid bits, e.g. an all-ones pattern on an all-ones stream.
- hit_any is registered together with hit.
- in_valid gaps stall the detector completely. No state changes except from cfg writes.
- A configuration written on cycle N applies to bits consumed from cycle N+1 onward.
- With SEQ_DET_HIT_CNT_EN, hit_cnt[i] increments on the same edge that sets hit[i]. The new count is visible in the same cycle as the hit pulse.

## Configuration
- Macro: SEQ_DET_HIT_CNT_EN.
- Defined:
  - NUM_PAT counters of CNT_WIDTH bits are built.
  - Each increments by 1 per hit and saturates at all-ones.
  - Cleared by rst and clr.
- Undefined:
  - No counter flops are built.
  - hit_cnt is tied to 0.
  - All other behaviour is identical.

## Test plan
All scenarios use SEQ_WIDTH=4, NUM_PAT=2, CNT_WIDTH=2 and the macro defined; bit numbers count valid bits from 1.
- Overlapping mode: pat0 = 1001, mask 1111, ovl = 1; stream 1001001001 with in_valid held high -> hit[0] pulses after bits 4, 7 and 10; hit_cnt[0] saturates at 3.
- Non-overlapping mode: same stream, ovl = 0 -> hit[0] pulses after bits 4 and 10 only.
- Don't-care mask: pat1 = 1001, mask 1001; stream 1111 -> hit[1] pulses after bit 4; pat0 = 1001 with mask 1111 does not hit.
- Fill guard and valid gaps: after rst, set pat0 = 0001, mask 1111, ovl = 1; feed 0, 0, 1 with idle cycles between bits -> no hit; feed 0,0,0,1 -> hit only after the 4th valid bit.
- Config collision and clear:
  - Write slot 0 in the same cycle as the completing bit -> no hit[0], hit[1] unaffected.
  - Assert clr mid-pattern -> hit_cnt returns to 0, config is retained, and the next match needs 4 new bits.
- Reset mid-operation: assert rst while hits are occurring -> next cycle hit = 0, hit_cnt = 0, all masks = 0, and no hit on any following input.
